// File: rtl/vga_pkg.sv
// Shared VGA overlay types, widths and default 640x480@60 timing constants.
package vga_pkg;

  localparam int COLOR_W = 4;
  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    coord_t x_start;
    coord_t x_end;
    coord_t y_start;
    coord_t y_end;
    color_t color;
  } win_t;

  // Inclusive unsigned range test; an inverted range (lo > hi) never matches.
  function automatic logic in_range(coord_t val, coord_t lo, coord_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_char_overlay_if.sv
// Video output bundle: sync, data enable, pixel color and frame marker.
interface vga_char_overlay_if;
  import vga_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   de;
  color_t pix_color;
  logic   frame_start;

  modport master (output hsync, vsync, de, pix_color, frame_start);
  modport slave  (input  hsync, vsync, de, pix_color, frame_start);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster position counters with combinational active/sync/frame decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t h_cnt,
  output coord_t v_cnt,
  output logic   active,
  output logic   hsync_n,
  output logic   vsync_n,
  output logic   frame_end,
  output logic   frame_origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT     = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT     = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_LO = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_LO = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   h_last;
  logic   v_last;

  always_comb begin
    h_last  = (h_cnt_q == H_LAST);
    v_last  = (v_cnt_q == V_LAST);
    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_n      = !in_range(h_cnt_q, H_SYNC_LO, H_SYNC_HI);
    vsync_n      = !in_range(v_cnt_q, V_SYNC_LO, V_SYNC_HI);
    frame_end    = h_last && v_last;
    frame_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

endmodule

// File: rtl/vga_char_overlay.sv
// VGA timing with a frame-synchronous rectangular color window overlay.
// Optional VGA_CHAR_BORDER_EN: window edge pixels show the inverted color.
module vga_char_overlay
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  coord_t char_x_start,
  input  coord_t char_x_end,
  input  coord_t char_y_start,
  input  coord_t char_y_end,
  input  color_t char_color,
  vga_char_overlay_if.master vid
);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   active;
  logic   hsync_n;
  logic   vsync_n;
  logic   frame_end;
  logic   frame_origin;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .active       (active),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .frame_end    (frame_end),
    .frame_origin (frame_origin)
  );

  // Window settings are only sampled on the last clock of a frame so a
  // frame is never drawn with a mix of old and new settings.
  win_t shd_q, shd_d;

  always_comb begin
    shd_d = shd_q;
    if (frame_end) begin
      shd_d.x_start = char_x_start;
      shd_d.x_end   = char_x_end;
      shd_d.y_start = char_y_start;
      shd_d.y_end   = char_y_end;
      shd_d.color   = char_color;
    end
  end

  logic   in_win;
  color_t win_color;
`ifdef VGA_CHAR_BORDER_EN
  logic   on_edge;
`endif

  always_comb begin
    in_win = active
          && in_range(h_cnt, shd_q.x_start, shd_q.x_end)
          && in_range(v_cnt, shd_q.y_start, shd_q.y_end);
`ifdef VGA_CHAR_BORDER_EN
    on_edge = (h_cnt == shd_q.x_start) || (h_cnt == shd_q.x_end)
           || (v_cnt == shd_q.y_start) || (v_cnt == shd_q.y_end);
    win_color = on_edge ? ~shd_q.color : shd_q.color;
`else
    win_color = shd_q.color;
`endif
  end

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  color_t pix_color_q, pix_color_d;
  logic   frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = hsync_n;
    vsync_d       = vsync_n;
    de_d          = active;
    pix_color_d   = in_win ? win_color : '0;
    frame_start_d = frame_origin;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      pix_color_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      shd_q         <= shd_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_color_q   <= pix_color_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.pix_color   = pix_color_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_char_overlay.sv
// Directed bench for vga_char_overlay on a reduced 80x55 raster (64x48 active).
module tb_vga_char_overlay;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

`ifdef VGA_CHAR_BORDER_EN
  localparam int WIN_PLAIN = 24, WIN_INV = 26, CLIP_PLAIN = 6, CLIP_INV = 6;
`else
  localparam int WIN_PLAIN = 50, WIN_INV = 0, CLIP_PLAIN = 12, CLIP_INV = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x_s, x_e, y_s, y_e;
  logic [3:0] col;

  vga_char_overlay_if vid();

  vga_char_overlay #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_x_start (x_s),
    .char_x_end   (x_e),
    .char_y_start (y_s),
    .char_y_end   (y_e),
    .char_color   (col),
    .vid          (vid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int fs_cnt, next_fs, hs_low, first_hs, vs_low, first_vs, de_cnt;
  int nz, nz_off, first_nz, min_x, max_x, min_y, max_y;
  int hist [16];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int xs, input int xe, input int ys, input int ye,
                         input logic [3:0] c);
    x_s = 10'(xs); x_e = 10'(xe); y_s = 10'(ys); y_e = 10'(ye); col = c;
  endtask

  // Returns the number of falling edges until frame_start is seen, -1 on timeout.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vid.frame_start && n < FRAME + 20);
    if (!vid.frame_start) n = -1;
  endtask

  // Called at the sample showing frame_start; sample i is raster position i.
  task automatic run_frame(input int chg_line, input logic [3:0] chg_col);
    int x, y;
    fs_cnt = 0; hs_low = 0; first_hs = -1; vs_low = 0; first_vs = -1; de_cnt = 0;
    nz = 0; nz_off = 0; first_nz = -1;
    min_x = 1 << 30; max_x = -1; min_y = 1 << 30; max_y = -1;
    for (int k = 0; k < 16; k++) hist[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      x = i % HT;
      y = i / HT;
      if (vid.frame_start) fs_cnt++;
      if (!vid.hsync) begin
        hs_low++;
        if (first_hs < 0) first_hs = i;
      end
      if (!vid.vsync) begin
        vs_low++;
        if (first_vs < 0) first_vs = i;
      end
      if (vid.de) de_cnt++;
      if (vid.pix_color != 4'h0) begin
        nz++;
        if (!vid.de) nz_off++;
        if (first_nz < 0) first_nz = i;
        if (x < min_x) min_x = x;
        if (x > max_x) max_x = x;
        if (y < min_y) min_y = y;
        if (y > max_y) max_y = y;
        hist[vid.pix_color]++;
      end
      if (chg_line >= 0 && i == chg_line * HT) col = chg_col;
      @(negedge clk);
    end
    next_fs = int'(vid.frame_start);
  endtask

  task automatic chk_win_a(input string tag);
    chk({tag, "_nz"}, nz, 50);
    chk({tag, "_first"}, first_nz, 5 * HT + 10);
    chk({tag, "_minx"}, min_x, 10);
    chk({tag, "_maxx"}, max_x, 19);
    chk({tag, "_miny"}, min_y, 5);
    chk({tag, "_maxy"}, max_y, 9);
    chk({tag, "_colA"}, hist[10], WIN_PLAIN);
    chk({tag, "_col5"}, hist[5], WIN_INV);
  endtask

  int n;

  initial begin
    set_win(10, 19, 5, 9, 4'hA);
    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(vid.hsync), 1);
    chk("rst_vsync", int'(vid.vsync), 1);
    chk("rst_de", int'(vid.de), 0);
    chk("rst_pix", int'(vid.pix_color), 0);
    chk("rst_fs", int'(vid.frame_start), 0);

    rst_n = 1'b1;
    wait_fs(n);
    chk("fs_latency", n, 1);

    // Frame 0: shadow still cleared, check raster timing.
    run_frame(-1, 4'h0);
    chk("f0_fs_cnt", fs_cnt, 1);
    chk("f0_period", next_fs, 1);
    chk("f0_hs_low", hs_low, HS * VT);
    chk("f0_hs_first", first_hs, HA + HF);
    chk("f0_vs_low", vs_low, VS * HT);
    chk("f0_vs_first", first_vs, (VA + VF) * HT);
    chk("f0_de_cnt", de_cnt, HA * VA);
    chk("f0_nz", nz, 0);

    // Frame 1: window A; color input changes mid-window and must not show.
    run_frame(7, 4'h5);
    chk_win_a("f1");
    chk("f1_off", nz_off, 0);

    // Frame 2: color 5 now; inverted x range written now takes effect next frame.
    set_win(30, 20, 5, 9, 4'h5);
    run_frame(-1, 4'h0);
    chk("f2_nz", nz, 50);
    chk("f2_col5", hist[5], WIN_PLAIN);
    chk("f2_colA", hist[10], WIN_INV);
    chk("f2_first", first_nz, 5 * HT + 10);

    // Frame 3: empty window.
    set_win(60, 1000, 45, 600, 4'h3);
    run_frame(-1, 4'h0);
    chk("f3_nz", nz, 0);

    // Frame 4: bounds beyond the active area are clipped.
    set_win(10, 19, 5, 9, 4'hA);
    run_frame(-1, 4'h0);
    chk("f4_nz", nz, 12);
    chk("f4_off", nz_off, 0);
    chk("f4_minx", min_x, 60);
    chk("f4_maxx", max_x, HA - 1);
    chk("f4_miny", min_y, 45);
    chk("f4_maxy", max_y, VA - 1);
    chk("f4_first", first_nz, 45 * HT + 60);
    chk("f4_col3", hist[3], CLIP_PLAIN);
    chk("f4_colC", hist[12], CLIP_INV);

    // Frame 5: reset inside the window interior.
    repeat (7 * HT + 12) @(negedge clk);
    chk("pre_rst_pix", int'(vid.pix_color), 10);
    chk("pre_rst_de", int'(vid.de), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_hsync", int'(vid.hsync), 1);
    chk("mid_rst_vsync", int'(vid.vsync), 1);
    chk("mid_rst_de", int'(vid.de), 0);
    chk("mid_rst_pix", int'(vid.pix_color), 0);
    chk("mid_rst_fs", int'(vid.frame_start), 0);
    rst_n = 1'b1;
    wait_fs(n);
    chk("fs_latency2", n, 1);

    // Frame 6: shadow cleared by reset even though inputs hold window A.
    run_frame(-1, 4'h0);
    chk("f6_nz", nz, 0);
    chk("f6_fs_cnt", fs_cnt, 1);
    chk("f6_period", next_fs, 1);

    // Frame 7: window A reloaded at the end of frame 6.
    run_frame(-1, 4'h0);
    chk_win_a("f7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
